alu_op_sequencer: RTL

Requester-side front end for the team's N-bit ALU (add/sub/and/or with v,c,n,z flags). It accepts operation requests over a valid/ready handshake and drives the ALU's a, b and control inputs from registers. It captures the ALU result and flags and returns them over a valid/ready response channel. It also keeps an accumulator so that operations can be chained, and counts completed operations.

---
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Valid/ready front end that drives a combinational N-bit ALU,
//             captures result/flags, keeps an accumulator and an op counter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_op_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic             req_acc,
    input  logic             acc_clr,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [1:0]       alu_control,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [N-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [N-1:0]       r_alu_a;
    logic [N-1:0]       r_alu_b;
    logic [1:0]         r_alu_ctrl;
    logic [N-1:0]       r_rsp_result;
    logic [3:0]         r_rsp_flags;
    logic [N-1:0]       r_acc;
    logic [CNT_W-1:0]   r_op_count;
    logic [N-1:0]       w_acc_operand;

    // A clear in the accepting cycle wins over the old accumulator value.
    assign w_acc_operand = acc_clr ? '0 : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_acc        <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (acc_clr) begin
                        r_acc <= '0;
                    end
                    if (req_valid) begin
                        r_alu_ctrl  <= req_op;
                        r_alu_b     <= req_b;
                        r_alu_a     <= req_acc ? w_acc_operand : req_a;
                        r_state     <= S_EXEC;
                        r_req_ready <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= alu_flags;
                    r_acc        <= alu_result;
                    r_op_count   <= r_op_count + 1'b1;
                    r_state      <= S_RESP;
                    r_rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Handshake flags are dedicated flops so they never glitch on decode.
    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_ctrl;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign acc         = r_acc;
    assign op_count    = r_op_count;

endmodule

`default_nettype wire
